// File: rtl/leaf_pkt_port.sv
`default_nettype none
// ============================================================================
//  Module   : leaf_pkt_port
//  Purpose  : PE-side port of a network leaf. A registered TX packet is held
//             on resend, and an RX FIFO with a saturating drop counter feeds
//             the PE.
//  Revision : 1.0 - initial release
// ============================================================================
module leaf_pkt_port #(
    parameter int payload_sz = 43,
    parameter int addr_sz    = 5,
    parameter int p_sz       = 49,
    parameter int fifo_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [payload_sz-1:0] tx_data,
    input  logic [addr_sz-1:0]    tx_dest,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [p_sz-1:0]       dout_leaf,
    input  logic                  resend,
    input  logic [p_sz-1:0]       din_leaf,
    output logic [payload_sz-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [7:0]            drop_cnt
);

    localparam int c_PTR_W = $clog2(fifo_depth);

    // ---------------- TX path ----------------
    logic [p_sz-1:0] dout_q, dout_d;

    assign tx_ready = reset & ~resend;

    always_comb begin
        dout_d = dout_q;
        if (!resend) begin
            dout_d = tx_valid ? {1'b1, tx_dest, tx_data} : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_leaf = dout_q;

    // ---------------- RX path ----------------
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [c_PTR_W:0]      wr_q, wr_d, rd_q, rd_d;
    logic [7:0]            drop_q, drop_d;
    logic [payload_sz-1:0] mem_q [fifo_depth];

    logic w_empty, w_full, w_in_valid, w_pop, w_push, w_drop;
    logic w_unused_addr;

    assign w_unused_addr = ^din_leaf[p_sz-2:payload_sz];

    assign w_empty    = (wr_q == rd_q);
    assign w_full     = (wr_q[c_PTR_W] != rd_q[c_PTR_W]) &&
                        (wr_q[c_PTR_W-1:0] == rd_q[c_PTR_W-1:0]);
    assign w_in_valid = reset & din_leaf[p_sz-1];
    assign w_pop      = ~w_empty & rx_ready;
    assign w_push     = w_in_valid & (~w_full | w_pop);
    assign w_drop     = w_in_valid & w_full & ~w_pop;

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        drop_d = drop_q;
        if (w_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (w_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (w_drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            drop_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            drop_q <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible behind rx_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_q[c_PTR_W-1:0]] <= din_leaf[payload_sz-1:0];
        end
    end

    assign rx_valid = ~w_empty;
    assign rx_data  = mem_q[rd_q[c_PTR_W-1:0]];
    assign drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_pkt_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_leaf_pkt_port
//  Purpose  : Scoreboard bench for leaf_pkt_port; expected TX packets and RX
//             payloads are queued by the stimulus and checked by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_leaf_pkt_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [42:0] tx_data;
    logic [4:0]  tx_dest;
    logic        tx_valid;
    logic        tx_ready;
    logic [48:0] dout_leaf;
    logic        resend;
    logic [48:0] din_leaf;
    logic [42:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [48:0] txq [$];
    logic [42:0] rxq [$];

    leaf_pkt_port dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_dest   (tx_dest),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .dout_leaf (dout_leaf),
        .resend    (resend),
        .din_leaf  (din_leaf),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] pkt(input logic v, input logic [4:0] a, input logic [42:0] d);
        return {v, a, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer a valid RX packet; address bits are scrambled since they must be ignored.
    task automatic rx_in(input logic [42:0] payload, input bit stored);
        din_leaf = pkt(1'b1, payload[4:0] ^ 5'h15, payload);
        if (stored) rxq.push_back(payload);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (txq.size() > 0) begin
            logic [48:0] e;
            e = txq.pop_front();
            n_cmp++;
            if (dout_leaf !== e) begin
                n_err++;
                $display("FAIL tx_pkt: got %0h expected %0h", dout_leaf, e);
            end
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            n_cmp++;
            if (rxq.size() == 0) begin
                n_err++;
                $display("FAIL rx_unexpected: got %0h expected no data", rx_data);
            end else begin
                logic [42:0] r;
                r = rxq.pop_front();
                if (rx_data !== r) begin
                    n_err++;
                    $display("FAIL rx_data: got %0h expected %0h", rx_data, r);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; tx_data = '0; tx_dest = '0; tx_valid = 1'b0;
        resend = 1'b0; rx_ready = 1'b0;
        din_leaf = pkt(1'b1, 5'd3, 43'h77);   // must be ignored in reset
        step(); step();
        check("rst_dout",     dout_leaf, 0);
        check("rst_tx_ready", tx_ready,  0);
        check("rst_rx_valid", rx_valid,  0);
        check("rst_drop",     drop_cnt,  0);
        din_leaf = '0;
        reset = 1'b1;
        step();
        check("rst_din_ignored", rx_valid, 0);
        check("tx_ready_idle",   tx_ready, 1);

        // Basic TX, all-ones corner, then idle
        tx_valid = 1'b1; tx_dest = 5'd5; tx_data = 43'h123;
        step(); txq.push_back(pkt(1'b1, 5'd5, 43'h123));
        tx_dest = 5'd31; tx_data = 43'h7FF_FFFF_FFFF;
        step(); txq.push_back(pkt(1'b1, 5'd31, 43'h7FF_FFFF_FFFF));
        tx_valid = 1'b0;
        step(); txq.push_back('0);

        // Resend hold for 3 cycles, new word must wait
        tx_valid = 1'b1; tx_dest = 5'd3; tx_data = 43'hABC;
        step(); txq.push_back(pkt(1'b1, 5'd3, 43'hABC));
        resend = 1'b1; tx_dest = 5'd7; tx_data = 43'h555;
        for (int k = 0; k < 3; k++) begin
            step(); txq.push_back(pkt(1'b1, 5'd3, 43'hABC));
            check("tx_ready_resend", tx_ready, 0);
        end
        resend = 1'b0;
        step(); txq.push_back(pkt(1'b1, 5'd7, 43'h555));
        check("tx_ready_after", tx_ready, 1);
        tx_valid = 1'b0;
        step(); txq.push_back('0);

        // RX ordering: 4 packets held, then drained
        for (int i = 1; i <= 4; i++) begin
            rx_in(43'(i), 1'b1);
            step();
        end
        din_leaf = pkt(1'b0, 5'd9, 43'hDEAD);   // valid bit clear: no push
        resend = 1'b1;                          // must not disturb RX
        step(); step();
        check("rx_valid_held", rx_valid, 1);
        check("rx_data_held",  rx_data,  1);
        check("rx_no_drop",    drop_cnt, 0);
        resend = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rx_empty_after_drain", rx_valid, 0);
        rx_ready = 1'b0;

        // Overflow: 6 into empty, 4 kept
        for (int i = 0; i < 6; i++) begin
            rx_in(43'(10 + i), i < 4);
            step();
        end
        din_leaf = '0;
        check("ovf_drop2", drop_cnt, 2);
        check("ovf_head",  rx_data,  10);

        // Full with simultaneous pop: no drop
        rx_in(43'd20, 1'b1);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        check("full_pop_nodrop", drop_cnt, 2);
        rx_in(43'd21, 1'b0);                    // occupancy still 4 -> dropped
        step();
        din_leaf = '0;
        check("full_still_full", drop_cnt, 3);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rx_ready = 1'b0;
        check("drain2_empty", rx_valid, 0);

        // Saturation
        for (int i = 0; i < 4; i++) begin
            rx_in(43'(30 + i), 1'b1);
            step();
        end
        for (int i = 0; i < 300; i++) begin
            rx_in(43'h1F00 + 43'(i), 1'b0);
            step();
        end
        din_leaf = '0;
        check("drop_saturated", drop_cnt, 255);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rx_ready = 1'b0;

        // Reset mid-traffic with 3 entries and a live TX packet
        rx_in(43'd40, 1'b1); step();
        rx_in(43'd41, 1'b1); step();
        rx_in(43'd42, 1'b1);
        tx_valid = 1'b1; tx_dest = 5'd9; tx_data = 43'h777;
        step(); txq.push_back(pkt(1'b1, 5'd9, 43'h777));
        check("pre_rst_valid", rx_valid, 1);
        reset = 1'b0;
        rx_in(43'd99, 1'b0);
        step();
        rxq.delete();
        check("mid_rst_tx_ready", tx_ready,  0);
        check("mid_rst_rx_valid", rx_valid,  0);
        check("mid_rst_drop",     drop_cnt,  0);
        check("mid_rst_dout",     dout_leaf, 0);
        reset = 1'b1; tx_valid = 1'b0; din_leaf = '0;
        step();
        check("post_rst_rx_valid", rx_valid,  0);
        check("post_rst_dout",     dout_leaf, 0);

        // Push and pop together at partial occupancy
        rx_in(43'd50, 1'b1); step();
        rx_in(43'd51, 1'b1); step();
        rx_in(43'd52, 1'b1);
        rx_ready = 1'b1;
        step();
        din_leaf = '0;
        step(); step();
        check("partial_empty", rx_valid, 0);
        rx_ready = 1'b0;
        step();
        check("scoreboard_rx_empty", rxq.size(), 0);
        check("scoreboard_tx_empty", txq.size(), 0);
        check("final_drop", drop_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
